// File: rtl/cache_ctrl_defs.sv
// Shared definitions for the cache control blocks: FSM state encodings and
// the clog2 helper used to size way indices.
package cache_ctrl_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/identity_comparator.sv
// Combinational equality check between two operands of width BW (1..32).
module identity_comparator #(
  parameter int BW = 20
) (
  input  logic [BW-1:0] i_opA,
  input  logic [BW-1:0] i_opB,
  output logic          o_eq
);

  assign o_eq = (i_opA == i_opB);

endmodule

// File: rtl/tag_search_controller.sv
// Sequential tag lookup for one cache set: reads one way per cycle from the
// tag array and checks it against the request tag on a single comparator.
module tag_search_controller
  import cache_ctrl_defs::*;
#(
  parameter int BW_TAG  = 20,
  parameter int N_WAYS  = 8,
  parameter int BW_WAYS = clog2(N_WAYS)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               req_i,
  input  logic [BW_TAG-1:0]  tag_i,
  input  logic               abort_i,
  output logic               ready_o,
  output logic               tag_rd_o,
  output logic [BW_WAYS-1:0] tag_addr_o,
  input  logic [BW_TAG-1:0]  tag_data_i,
  input  logic               valid_data_i,
  output logic               done_o,
  output logic               hit_o,
  output logic [BW_WAYS-1:0] way_o
);

  localparam logic [BW_WAYS-1:0] LAST_WAY = BW_WAYS'(N_WAYS - 1);

  state_t              r_state;
  logic [BW_TAG-1:0]   r_tagQ;
  logic                r_issueLast;
  logic                r_cmpValid;
  logic                r_cmpLast;
  logic [BW_WAYS-1:0]  r_cmpPtr;
  logic                w_tagEq;
  logic                w_match;

  identity_comparator #(
    .BW (BW_TAG)
  ) u_cmp (
    .i_opA (r_tagQ),
    .i_opB (tag_data_i),
    .o_eq  (w_tagEq)
  );

  // Tag data only belongs to a way when it follows a read strobe by one cycle.
  assign w_match = r_cmpValid & w_tagEq & valid_data_i;

  // The issue pointer stops on the last-way flag rather than by overflowing,
  // so power-of-two way counts never wrap back to way 0.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_tagQ      <= '0;
      r_issueLast <= 1'b0;
      r_cmpValid  <= 1'b0;
      r_cmpLast   <= 1'b0;
      r_cmpPtr    <= '0;
      ready_o     <= 1'b1;
      tag_rd_o    <= 1'b0;
      tag_addr_o  <= '0;
      done_o      <= 1'b0;
      hit_o       <= 1'b0;
      way_o       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          done_o <= 1'b0;
          if (req_i) begin
            r_state     <= SEARCH;
            r_tagQ      <= tag_i;
            r_issueLast <= 1'b0;
            r_cmpValid  <= 1'b0;
            r_cmpLast   <= 1'b0;
            ready_o     <= 1'b0;
            tag_rd_o    <= 1'b1;
            tag_addr_o  <= '0;
          end
        end

        SEARCH: begin
          if (abort_i) begin
            r_state    <= IDLE;
            r_cmpValid <= 1'b0;
            ready_o    <= 1'b1;
            tag_rd_o   <= 1'b0;
          end else if (w_match || (r_cmpValid && r_cmpLast)) begin
            r_state    <= DONE;
            r_cmpValid <= 1'b0;
            tag_rd_o   <= 1'b0;
            done_o     <= 1'b1;
            hit_o      <= w_match;
            if (w_match) way_o <= r_cmpPtr;
          end else begin
            r_cmpValid <= tag_rd_o;
            r_cmpPtr   <= tag_addr_o;
            r_cmpLast  <= r_issueLast;
            if (tag_rd_o) begin
              if (r_issueLast) begin
                tag_rd_o <= 1'b0;
              end else begin
                tag_addr_o  <= tag_addr_o + 1'b1;
                r_issueLast <= ((tag_addr_o + 1'b1) == LAST_WAY);
              end
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          done_o  <= 1'b0;
          ready_o <= 1'b1;
        end

        default: begin
          r_state  <= IDLE;
          done_o   <= 1'b0;
          ready_o  <= 1'b1;
          tag_rd_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tag_search_controller.sv
// Self-checking bench for tag_search_controller: directed scenarios plus
// randomized lookups checked against a first-match reference model.
module tb_tag_search_controller;

  localparam int BW_TAG  = 20;
  localparam int N_WAYS  = 8;
  localparam int BW_WAYS = 3;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               req = 1'b0;
  logic [BW_TAG-1:0]  tagIn = '0;
  logic               abort = 1'b0;
  logic               ready;
  logic               tagRd;
  logic [BW_WAYS-1:0] tagAddr;
  logic [BW_TAG-1:0]  tagData = '0;
  logic               validData = 1'b0;
  logic               done;
  logic               hit;
  logic [BW_WAYS-1:0] way;

  logic [BW_TAG-1:0]  memTag [N_WAYS];
  logic               memValid [N_WAYS];
  logic [BW_TAG-1:0]  curTag = '0;

  int checks = 0;
  int failures = 0;
  logic               modelHit = 1'b0;
  logic [BW_WAYS-1:0] modelWay = '0;

  tag_search_controller #(
    .BW_TAG  (BW_TAG),
    .N_WAYS  (N_WAYS),
    .BW_WAYS (BW_WAYS)
  ) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .req_i        (req),
    .tag_i        (tagIn),
    .abort_i      (abort),
    .ready_o      (ready),
    .tag_rd_o     (tagRd),
    .tag_addr_o   (tagAddr),
    .tag_data_i   (tagData),
    .valid_data_i (validData),
    .done_o       (done),
    .hit_o        (hit),
    .way_o        (way)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Tag array model: one-cycle read latency. Idle cycles return a valid copy
  // of the request tag so any compare outside a read window would falsely hit.
  always @(posedge clock) begin
    if (tagRd) begin
      tagData   <= memTag[tagAddr];
      validData <= memValid[tagAddr];
    end else begin
      tagData   <= curTag;
      validData <= 1'b1;
    end
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Fill every way with a tag guaranteed to differ from t; valid is random.
  task automatic fillMemMiss(input logic [BW_TAG-1:0] t);
    logic [BW_TAG-1:0] x;
    for (int i = 0; i < N_WAYS; i++) begin
      x = BW_TAG'($urandom);
      if (x == '0) x = 1;
      memTag[i]   = t ^ x;
      memValid[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // One lookup from accept to the cycle after done. Expectations come from a
  // first-valid-match search of the array model; abortAt >= latency means none.
  task automatic applyStimulus(input logic [BW_TAG-1:0] t, input int abortAt,
                               input bit holdReq);
    int guard;
    int lat;
    int lastRead;
    int expWay;
    int a;
    bit expHit;

    guard = 0;
    @(negedge clock);
    while (!ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("readyBeforeAccept", 32'(ready), 32'd1);

    expHit = 1'b0;
    expWay = 0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (!expHit && memValid[i] && memTag[i] == t) begin
        expHit = 1'b1;
        expWay = i;
      end
    end
    lat      = expHit ? expWay + 3 : N_WAYS + 2;
    lastRead = expHit ? ((expWay + 2 < N_WAYS) ? expWay + 2 : N_WAYS) : N_WAYS;
    a        = (abortAt > 0 && abortAt < lat) ? abortAt : 0;

    curTag = t;
    tagIn  = t;
    req    = 1'b1;

    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clock);
      #1;
      if (c == 1 && !holdReq) req = 1'b0;
      abort = (c == a);
      if (a > 0 && c == a + 1) begin
        checkOutput("abortReady", 32'(ready), 32'd1);
        checkOutput("abortTagRd", 32'(tagRd), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        checkOutput("abortHitHeld", 32'(hit), 32'(modelHit));
        checkOutput("abortWayHeld", 32'(way), 32'(modelWay));
        break;
      end
      checkOutput("tagRd", 32'(tagRd), 32'(c <= lastRead));
      if (c <= lastRead) checkOutput("tagAddr", 32'(tagAddr), 32'(c - 1));
      checkOutput("done", 32'(done), 32'(c == lat));
      checkOutput("ready", 32'(ready), 32'(c == lat + 1));
      if (c == lat) begin
        modelHit = expHit;
        if (expHit) modelWay = BW_WAYS'(expWay);
      end
      checkOutput("hit", 32'(hit), 32'(modelHit));
      checkOutput("way", 32'(way), 32'(modelWay));
    end
    abort = 1'b0;
  endtask

  initial begin
    logic [BW_TAG-1:0] t;
    int ab;

    $display("[TB] starting tag_search_controller bench");
    for (int i = 0; i < N_WAYS; i++) begin
      memTag[i]   = '0;
      memValid[i] = 1'b0;
    end

    repeat (2) @(negedge clock);
    checkOutput("resetReady", 32'(ready), 32'd1);
    checkOutput("resetTagRd", 32'(tagRd), 32'd0);
    checkOutput("resetTagAddr", 32'(tagAddr), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetHit", 32'(hit), 32'd0);
    checkOutput("resetWay", 32'(way), 32'd0);
    reset = 1'b0;

    // Hit on way 3.
    t = 20'hABCDE;
    fillMemMiss(t);
    memTag[3] = t;
    memValid[3] = 1'b1;
    applyStimulus(t, 0, 1'b0);

    // Miss, with an equal but invalid tag in way 5.
    fillMemMiss(t);
    memTag[5] = t;
    memValid[5] = 1'b0;
    applyStimulus(t, 0, 1'b0);

    // Duplicate matches in ways 0 and 6: the lowest way wins.
    fillMemMiss(t);
    memTag[0] = t; memValid[0] = 1'b1;
    memTag[6] = t; memValid[6] = 1'b1;
    applyStimulus(t, 0, 1'b0);

    // Sole match in the last way.
    fillMemMiss(t);
    memTag[7] = t; memValid[7] = 1'b1;
    applyStimulus(t, 0, 1'b0);

    // Abort in cycle 3 while the way-1 match arrives.
    fillMemMiss(t);
    memTag[1] = t; memValid[1] = 1'b1;
    applyStimulus(t, 3, 1'b0);

    // Back-to-back with req held high.
    t = 20'h12345;
    fillMemMiss(t);
    memTag[2] = t; memValid[2] = 1'b1;
    applyStimulus(t, 0, 1'b1);
    applyStimulus(t, 0, 1'b1);
    fillMemMiss(t);
    applyStimulus(t, 0, 1'b0);

    // Reset asserted while way 4 is being read.
    t = 20'h0F0F0;
    fillMemMiss(t);
    memTag[7] = t; memValid[7] = 1'b1;
    applyStimulus(t, 0, 1'b0);
    fillMemMiss(t);
    @(negedge clock);
    curTag = t;
    tagIn  = t;
    req    = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    req = 1'b0;
    checkOutput("preResetTagAddr", 32'(tagAddr), 32'd4);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midResetReady", 32'(ready), 32'd1);
    checkOutput("midResetTagRd", 32'(tagRd), 32'd0);
    checkOutput("midResetDone", 32'(done), 32'd0);
    checkOutput("midResetHit", 32'(hit), 32'd0);
    checkOutput("midResetWay", 32'(way), 32'd0);
    modelHit = 1'b0;
    modelWay = '0;
    @(negedge clock);
    reset = 1'b0;
    memTag[4] = t; memValid[4] = 1'b1;
    applyStimulus(t, 0, 1'b0);

    // Randomized lookups, occasionally aborted.
    for (int n = 0; n < 40; n++) begin
      t = BW_TAG'($urandom);
      fillMemMiss(t);
      for (int i = 0; i < N_WAYS; i++) begin
        if ($urandom_range(0, 3) == 0) memTag[i] = t;
      end
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N_WAYS + 1)) : 0;
      applyStimulus(t, ab, 1'($urandom_range(0, 1)));
    end
    req = 1'b0;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
